// File: rtl/mips_pkg.sv
// Shared definitions for the memory-access stage: opcodes, FSM states and
// byte-lane geometry, plus small opcode-classification helpers.
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FIN    = 2'd2
  } lsu_state_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load_op(op) || (op == OP_SW) || (op == OP_SB);
  endfunction

  // Word accesses are the only ones that can fault on alignment.
  function automatic logic is_word_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane steering: store replication and byte enables,
// load byte extraction with sign or zero extension (little-endian lanes).
module byte_lane_unit
  import mips_pkg::*;
(
  input  logic [5:0]           opcode,
  input  logic [1:0]           lane,
  input  logic [31:0]          store_data,
  input  logic [31:0]          rdata,
  output logic [NUM_LANES-1:0] be,
  output logic [31:0]          wdata,
  output logic [31:0]          load_data
);

  logic [LANE_W-1:0] rbyte;

  // NOTE: every output gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    be        = '1;
    wdata     = store_data;
    rbyte     = rdata[LANE_W*lane +: LANE_W];
    load_data = rdata;
    case (opcode)
      OP_SB: begin
        be    = NUM_LANES'(1) << lane;
        wdata = {NUM_LANES{store_data[LANE_W-1:0]}};
      end
      OP_LB:   load_data = {{(32-LANE_W){rbyte[LANE_W-1]}}, rbyte};
      OP_LBU:  load_data = {{(32-LANE_W){1'b0}}, rbyte};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle memory-access stage: address generation, alignment check,
// req/ack transaction with timeout, and load write-back to the register block.
module load_store_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [31:0]       base,
  input  logic [15:0]       offset,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        rt_in,
  load_store_unit_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              wb_en,
  output logic [4:0]        wb_rt,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_align,
  output logic              err_timeout
);

  lsu_state_t  state;
  logic [5:0]  op_q;
  logic [1:0]  lane_q;
  logic [4:0]  rt_q;
  logic [7:0]  cnt;

  logic [31:0] ea;
  logic [5:0]  blu_op;
  logic [1:0]  blu_lane;
  logic [3:0]  blu_be;
  logic [31:0] blu_wdata;
  logic [31:0] blu_load;

  assign ea = base + 32'($signed(offset));

  // The steering unit sees live inputs while capturing and the captured
  // opcode/lane while the access is in flight.
  assign blu_op   = (state == IDLE) ? opcode  : op_q;
  assign blu_lane = (state == IDLE) ? ea[1:0] : lane_q;

  byte_lane_unit u_byte_lane (
    .opcode     (blu_op),
    .lane       (blu_lane),
    .store_data (store_data),
    .rdata      (mem.mem_rdata),
    .be         (blu_be),
    .wdata      (blu_wdata),
    .load_data  (blu_load)
  );

  assign busy = (state != IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      lane_q        <= '0;
      rt_q          <= '0;
      cnt           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
      done          <= 1'b0;
      wb_en         <= 1'b0;
      wb_rt         <= '0;
      wb_data       <= '0;
      err_align     <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      done        <= 1'b0;
      wb_en       <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_mem_op(opcode)) begin
            op_q          <= opcode;
            lane_q        <= ea[1:0];
            rt_q          <= rt_in;
            cnt           <= '0;
            mem.mem_we    <= ~is_load_op(opcode);
            mem.mem_addr  <= ea[ADDR_W-1:0];
            mem.mem_be    <= blu_be;
            mem.mem_wdata <= blu_wdata;
            if (is_word_op(opcode) && (ea[1:0] != 2'b00)) begin
              state     <= FIN;
              done      <= 1'b1;
              err_align <= 1'b1;
            end else begin
              state       <= ACCESS;
              mem.mem_req <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // Ack on the final count still completes normally.
          if (mem.mem_ack) begin
            state       <= FIN;
            mem.mem_req <= 1'b0;
            done        <= 1'b1;
            if (is_load_op(op_q)) begin
              wb_en   <= 1'b1;
              wb_rt   <= rt_q;
              wb_data <= blu_load;
            end
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state       <= FIN;
            mem.mem_req <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// ops compared against an arithmetic reference model of the access rules.
module tb_load_store_unit;
  import mips_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] base;
  logic [15:0] offset;
  logic [31:0] store_data;
  logic [4:0]  rt_in;
  logic        busy, done, wb_en, err_align, err_timeout;
  logic [4:0]  wb_rt;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .base        (base),
    .offset      (offset),
    .store_data  (store_data),
    .rt_in       (rt_in),
    .mem         (mif),
    .busy        (busy),
    .done        (done),
    .wb_en       (wb_en),
    .wb_rt       (wb_rt),
    .wb_data     (wb_data),
    .err_align   (err_align),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Runs one op starting at the current negedge (cycle 0). ack_at = 0 means
  // memory never acknowledges.
  task automatic run_op(input string name, input logic [5:0] op,
                        input logic [31:0] b, input logic [15:0] off,
                        input logic [31:0] sd, input logic [4:0] rt,
                        input int ack_at, input logic [31:0] rd,
                        input bit late_ack, input bit busy_start);
    logic [31:0] ea, exp_wd, exp_wb, byte_v;
    logic [3:0]  exp_be;
    int          lane, done_at;
    bit          is_load, misal, to, exp_wbe;
    ea      = b + 32'($signed(off));
    lane    = int'(ea % 4);
    is_load = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    misal   = ((op == OP_LW) || (op == OP_SW)) && (lane != 0);
    to      = !misal && (ack_at == 0);
    exp_wbe = is_load && !misal && !to;
    exp_be  = (op == OP_SB) ? 4'(1 << lane) : 4'hF;
    exp_wd  = (op == OP_SB) ? {24'd0, sd[7:0]} * 32'h01010101 : sd;
    byte_v  = (rd >> (8 * lane)) % 256;
    if (op == OP_LW)                       exp_wb = rd;
    else if (op == OP_LB && byte_v >= 128) exp_wb = byte_v - 32'd256;
    else                                   exp_wb = byte_v;
    done_at = misal ? 1 : (ack_at > 0 ? ack_at + 1 : TIMEOUT + 1);

    start = 1'b1; opcode = op; base = b; offset = off; store_data = sd; rt_in = rt;
    for (int c = 1; c <= done_at; c++) begin
      @(negedge clk);
      start = 1'b0; base = $urandom; offset = 16'($urandom);
      store_data = $urandom; rt_in = 5'($urandom);
      mif.mem_ack = 1'b0; mif.mem_rdata = $urandom;
      checks++;
      if ({mif.mem_req, busy, done} !== {(c < done_at) && !misal, 1'b1, c == done_at}) begin
        failures++;
        $display("FAIL %s ctl c=%0d req/busy/done got=%b want=%b", name, c,
                 {mif.mem_req, busy, done}, {(c < done_at) && !misal, 1'b1, c == done_at});
      end
      if ((c < done_at) && !misal) begin
        checks++;
        if ({mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata} !== {!is_load, exp_be, ea, exp_wd}) begin
          failures++;
          $display("FAIL %s bus c=%0d we=%b be=%b addr=%h wdata=%h want we=%b be=%b addr=%h wdata=%h",
                   name, c, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata,
                   !is_load, exp_be, ea, exp_wd);
        end
      end
      if (c == done_at) begin
        checks++;
        if ({wb_en, err_align, err_timeout} !== {exp_wbe, misal, to}) begin
          failures++;
          $display("FAIL %s flags wb_en/align/timeout got=%b want=%b", name,
                   {wb_en, err_align, err_timeout}, {exp_wbe, misal, to});
        end
        if (exp_wbe) begin
          checks++;
          if ({wb_rt, wb_data} !== {rt, exp_wb}) begin
            failures++;
            $display("FAIL %s wb got rt=%0d data=%h want rt=%0d data=%h", name,
                     wb_rt, wb_data, rt, exp_wb);
          end
        end
        if (late_ack) begin
          mif.mem_ack = 1'b1; mif.mem_rdata = $urandom;
        end
      end
      if (c == ack_at) begin
        mif.mem_ack = 1'b1; mif.mem_rdata = rd;
      end
      if (busy_start && c == 1) begin
        start = 1'b1; opcode = OP_SW; base = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0; mif.mem_ack = 1'b0;
    checks++;
    if ({mif.mem_req, busy, done, wb_en, err_align, err_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL %s idle got req/busy/done/wb/al/to=%b want=000000", name,
               {mif.mem_req, busy, done, wb_en, err_align, err_timeout});
    end
    if (!misal) begin
      checks++;
      if (mif.mem_addr !== ea) begin
        failures++;
        $display("FAIL %s addr_hold got=%h want=%h", name, mif.mem_addr, ea);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = '0; base = '0; offset = '0;
    store_data = '0; rt_in = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata, busy, done,
         wb_en, wb_rt, wb_data, err_align, err_timeout} !== '0) begin
      failures++;
      $display("FAIL reset outputs not all zero req=%b addr=%h be=%b busy=%b done=%b wb_data=%h",
               mif.mem_req, mif.mem_addr, mif.mem_be, busy, done, wb_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("lw_basic",  OP_LW,  32'h100,  16'hFFFC, 32'h0,        5'd7,  3, 32'hDEADBEEF, 1'b0, 1'b0);
    run_op("sb_lane3",  OP_SB,  32'h200,  16'h0003, 32'h000000A5, 5'd3,  1, 32'h0,        1'b0, 1'b0);
    run_op("lb_lane2",  OP_LB,  32'h1000, 16'h0002, 32'h0,        5'd9,  2, 32'h0080FF00, 1'b0, 1'b0);
    run_op("lbu_lane2", OP_LBU, 32'h1000, 16'h0002, 32'h0,        5'd10, 1, 32'h0080FF00, 1'b0, 1'b0);
    run_op("sw_misal",  OP_SW,  32'h100,  16'h0002, 32'h12345678, 5'd1,  1, 32'h0,        1'b0, 1'b0);
    run_op("lw_rt0",    OP_LW,  32'h40,   16'h0000, 32'h0,        5'd0,  1, 32'hCAFEF00D, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op("lw_timeout", OP_LW, 32'h300, 16'h0004, 32'h0, 5'd4, 0, 32'h0, 1'b1, 1'b0);
    run_op("sw_ack_final", OP_SW, 32'h400, 16'h0000, 32'h55AA55AA, 5'd2, TIMEOUT, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start();
    start = 1'b1; opcode = 6'b000000; base = 32'h800;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({mif.mem_req, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL bad_opcode c=%0d req/busy/done got=%b want=000", c, {mif.mem_req, busy, done});
      end
    end
    run_op("start_while_busy", OP_LW, 32'h500, 16'h0008, 32'h0, 5'd12, 4, 32'h01020304, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midop();
    start = 1'b1; opcode = OP_LW; base = 32'h600; offset = 16'h0; rt_in = 5'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mif.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid req c1 got=%b want=1", mif.mem_req);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({mif.mem_req, busy, done, mif.mem_addr} !== 35'b0) begin
      failures++;
      $display("FAIL rst_mid c3 req/busy/done=%b addr=%h want 000 addr=0",
               {mif.mem_req, busy, done}, mif.mem_addr);
    end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    checks++;
    if ({mif.mem_req, busy, done, wb_en} !== 4'b0) begin
      failures++;
      $display("FAIL rst_late_ack got req/busy/done/wb=%b want=0000", {mif.mem_req, busy, done, wb_en});
    end
  endtask

  task automatic test_back_to_back_random();
    logic [5:0]  ops [5];
    logic [5:0]  op;
    logic [31:0] b;
    logic [15:0] off;
    int          ack_at;
    ops = '{OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB};
    for (int i = 0; i < 40; i++) begin
      op  = ops[$urandom_range(0, 4)];
      b   = $urandom;
      off = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        b[1:0] = 2'b00; off[1:0] = 2'b00;
      end
      ack_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      run_op("random", op, b, off, $urandom, 5'($urandom), ack_at, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ignored_start();
    test_reset_midop();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
